// File: rtl/poly_pipeline_pkg.sv
// Shared constants and types for the five-stage polynomial evaluator.
package poly_pipeline_pkg;

    localparam int LATENCY    = 5;
    localparam int DEF_COEF_A = 2;
    localparam int DEF_COEF_B = 0;
    localparam int DEF_COEF_C = 2;

    // Widest stage payload the record can describe (two WIDTH-bit terms up to 32 bits each).
    localparam int STAGE_DW = 64;

    typedef struct packed {
        logic                vld;
        logic [STAGE_DW-1:0] data;
    } stage_t;

endpackage

// File: rtl/poly_pipeline_stage_reg.sv
// One pipeline slot: valid bit plus data register, advancing only on en_i.
module pipe_stage_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             vld_i,
    input  logic [WIDTH-1:0] d_i,
    output logic             vld_o,
    output logic [WIDTH-1:0] q_o
);

    logic             vld_q;
    logic [WIDTH-1:0] data_q;

    // Data loads only behind a valid token so bubbles never clobber the last result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else if (en_i) begin
            vld_q <= vld_i;
            if (vld_i) data_q <= d_i;
        end
    end

    assign vld_o = vld_q;
    assign q_o   = data_q;

endmodule

// File: rtl/poly_pipeline.sv
// Pipelined A*x^2 + B*x + C (mod 2^WIDTH) with valid/ready flow control.
module poly_pipeline
    import poly_pipeline_pkg::*;
#(
    parameter int               WIDTH  = 8,
    parameter logic [WIDTH-1:0] COEF_A = WIDTH'(DEF_COEF_A),
    parameter logic [WIDTH-1:0] COEF_B = WIDTH'(DEF_COEF_B),
    parameter logic [WIDTH-1:0] COEF_C = WIDTH'(DEF_COEF_C)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_o
);

    logic [LATENCY:0]     vld_pipe;
    logic                 en;

    logic [WIDTH-1:0]     s1_q, s4_q, s5_q;
    logic [2*WIDTH-1:0]   s2_q, s3_q;
    logic [WIDTH-1:0]     sq_d, ax2_d, bx_d, sum_d, res_d;

    // Whole pipe moves as one; a held output result stalls every stage.
    assign en         = !vld_pipe[LATENCY] || out_ready_i;
    assign in_ready_o = en;
    assign vld_pipe[0] = in_valid_i;

    assign sq_d  = s1_q * s1_q;
    assign ax2_d = COEF_A * s2_q[2*WIDTH-1:WIDTH];
    assign bx_d  = COEF_B * s2_q[WIDTH-1:0];
    assign sum_d = s3_q[2*WIDTH-1:WIDTH] + s3_q[WIDTH-1:0];
    assign res_d = s4_q + COEF_C;

    pipe_stage_reg #(.WIDTH(WIDTH)) u_s1 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .vld_i(vld_pipe[0]),
        .d_i(in_i), .vld_o(vld_pipe[1]), .q_o(s1_q));

    pipe_stage_reg #(.WIDTH(2*WIDTH)) u_s2 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .vld_i(vld_pipe[1]),
        .d_i({sq_d, s1_q}), .vld_o(vld_pipe[2]), .q_o(s2_q));

    pipe_stage_reg #(.WIDTH(2*WIDTH)) u_s3 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .vld_i(vld_pipe[2]),
        .d_i({ax2_d, bx_d}), .vld_o(vld_pipe[3]), .q_o(s3_q));

    pipe_stage_reg #(.WIDTH(WIDTH)) u_s4 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .vld_i(vld_pipe[3]),
        .d_i(sum_d), .vld_o(vld_pipe[4]), .q_o(s4_q));

    pipe_stage_reg #(.WIDTH(WIDTH)) u_s5 (
        .clk(clk), .rst_n(rst_n), .en_i(en), .vld_i(vld_pipe[4]),
        .d_i(res_d), .vld_o(vld_pipe[5]), .q_o(s5_q));

    assign out_valid_o = vld_pipe[LATENCY];
    assign out_o       = s5_q;

endmodule

// File: tb/tb_poly_pipeline.sv
// Directed checks of the polynomial pipeline: latency, streaming, stall, wrap, reset, 16-bit variant.
module tb_poly_pipeline;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [7:0]  in_d, out_d;
    logic        in_valid16, in_ready16, out_valid16, out_ready16;
    logic [15:0] in16, out16;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    poly_pipeline #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_i(in_d),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_o(out_d));

    poly_pipeline #(.WIDTH(16), .COEF_A(16'd1), .COEF_B(16'd3), .COEF_C(16'd5)) dut16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid16), .in_ready_o(in_ready16), .in_i(in16),
        .out_valid_o(out_valid16), .out_ready_i(out_ready16), .out_o(out16));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 0; in_d = 0; out_ready = 1;
        in_valid16 = 0; in16 = 0; out_ready16 = 1;
        step(); step();
        n_cmp++; if (out_d !== 8'd0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out: got out=%0d v=%b, want 0/0", out_d, out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_ready: got %b, want 1", in_ready); end
        n_cmp++; if (out16 !== 16'd0 || out_valid16 !== 1'b0) begin
            n_err++; $display("FAIL reset_out16: got out=%0d v=%b, want 0/0", out16, out_valid16); end
        #3 rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        in_d = 8'd2; in_valid = 1; out_ready = 1;
        step();
        in_valid = 0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (out_valid !== 1'b0 || out_d !== 8'd0) begin
                n_err++; $display("FAIL single_latency e+%0d: got out=%0d v=%b, want 0/0", i, out_d, out_valid); end
            if (i < 3) step();
        end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_d !== 8'd10) begin
            n_err++; $display("FAIL single_result: got out=%0d v=%b, want 10/1", out_d, out_valid); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++; if (out_valid !== 1'b0 || out_d !== 8'd10) begin
                n_err++; $display("FAIL single_hold %0d: got out=%0d v=%b, want 10/0", i, out_d, out_valid); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_t [8] = '{8'd10, 8'd20, 8'd34, 8'd52, 8'd74, 8'd100, 8'd130, 8'd164};
        out_ready = 1;
        for (int c = 0; c < 12; c++) begin
            in_valid = (c < 8);
            in_d     = 8'(2 + c);
            step();
            if (c >= 4) begin
                n_cmp++; if (out_valid !== 1'b1 || out_d !== exp_t[c-4]) begin
                    n_err++; $display("FAIL stream[%0d]: got out=%0d v=%b, want %0d/1", c-4, out_d, out_valid, exp_t[c-4]); end
            end
        end
        in_valid = 0;
        step();
        n_cmp++; if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL stream_drain: got v=%b, want 0", out_valid); end
    endtask

    task automatic test_stall();
        logic [7:0] exp_t [3] = '{8'd20, 8'd34, 8'd52};
        logic [7:0] got [$];
        int guard;
        out_ready = 1;
        for (int c = 0; c < 3; c++) begin
            in_d = 8'(3 + c); in_valid = 1;
            step();
        end
        in_valid = 0;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 10) begin step(); guard++; end
        n_cmp++; if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL stall_wait: got v=%b, want 1 within 10 cycles", out_valid); end
        out_ready = 0;
        for (int i = 0; i < 6; i++) begin
            #1;
            n_cmp++; if (in_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_ready %0d: got %b, want 0", i, in_ready); end
            in_valid = 1; in_d = 8'd99;
            step();
            in_valid = 0;
            n_cmp++; if (out_valid !== 1'b1 || out_d !== 8'd20) begin
                n_err++; $display("FAIL stall_hold %0d: got out=%0d v=%b, want 20/1", i, out_d, out_valid); end
        end
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            if (out_valid === 1'b1) got.push_back(out_d);
            step();
        end
        n_cmp++; if (got.size() !== 3) begin
            n_err++; $display("FAIL stall_count: got %0d results, want 3", got.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (i >= got.size() || got[i] !== exp_t[i]) begin
                n_err++; $display("FAIL stall_order[%0d]: got %0d, want %0d", i, (i < got.size()) ? got[i] : 8'hxx, exp_t[i]); end
        end
    endtask

    task automatic test_wrap();
        out_ready = 1;
        in_d = 8'd12;  in_valid = 1; step();
        in_d = 8'd255;               step();
        in_valid = 0;
        step(); step(); step();
        n_cmp++; if (out_valid !== 1'b1 || out_d !== 8'd34) begin
            n_err++; $display("FAIL wrap_12: got out=%0d v=%b, want 34/1", out_d, out_valid); end
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_d !== 8'd4) begin
            n_err++; $display("FAIL wrap_255: got out=%0d v=%b, want 4/1", out_d, out_valid); end
        step();
    endtask

    task automatic test_async_reset();
        logic seen;
        in_d = 8'd7; in_valid = 1; out_ready = 1;
        step();
        in_valid = 0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (out_d !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL async_reset: got out=%0d v=%b rdy=%b, want 0/0/1", out_d, out_valid, in_ready); end
        step(); step();
        #2 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid !== 1'b0 || out_d === 8'd100) seen = 1'b1;
        end
        n_cmp++; if (seen !== 1'b0) begin
            n_err++; $display("FAIL reset_flush: got stale result after reset, want none"); end
    endtask

    task automatic test_width16();
        in16 = 16'd100; in_valid16 = 1; out_ready16 = 1;
        step();
        in_valid16 = 0;
        step(); step(); step();
        n_cmp++; if (out_valid16 !== 1'b0) begin
            n_err++; $display("FAIL w16_early: got v=%b, want 0", out_valid16); end
        step();
        n_cmp++; if (out_valid16 !== 1'b1 || out16 !== 16'd10305) begin
            n_err++; $display("FAIL w16_result: got out=%0d v=%b, want 10305/1", out16, out_valid16); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_wrap();
        test_async_reset();
        test_width16();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
